mod_addsub_pipe: RTL

Parametrised, pipelined modular add/subtract unit for the NTT butterfly datapath. It processes LANES independent coefficient pairs per beat, selectable per beat as (x+y) mod q or (x−y) mod q. It has a valid/ready handshake with full backpressure and an opaque tag carried alongside the data. It is the generalised replacement for the single-lane combinational modular subtractor and sits between the twiddle multiplier/reducer and the coefficient memory write-back.

---
 rtl/ntt_pkg.sv | 14 +
 rtl/mod_addsub_lane.sv | 42 ++++
 rtl/mod_addsub_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants for the NTT butterfly datapath.
package ntt_pkg;

    // Operation select for the modular add/subtract unit.
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Default coefficient / modulus width.
    localparam int COEF_W = 28;

    // NTT modulus used by the default datapath configuration.
    localparam logic [COEF_W-1:0] Q_DEFAULT = 28'd268369921;

endpackage

// File: rtl/mod_addsub_lane.sv
// Single-lane modular add/subtract, split into a raw sum/difference half and a
// compare/correct half so the parent can place a register between them.
module mod_addsub_lane
    import ntt_pkg::*;
#(
    parameter int WIDTH = COEF_W
) (
    // raw half
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_op,
    output logic [WIDTH:0]   o_raw,
    // correct half
    input  logic [WIDTH:0]   i_raw,
    input  logic             i_cor_op,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_z
);

    logic [WIDTH-1:0] w_plus_q;
    logic [WIDTH-1:0] w_minus_q;
    logic             w_ge_q;

    // Raw sum or difference, one extra bit for carry / borrow.
    always_comb begin
        if (i_op == OP_ADD) o_raw = {1'b0, i_x} + {1'b0, i_y};
        else                o_raw = {1'b0, i_x} - {1'b0, i_y};
    end

    // Only the low WIDTH bits of the corrected value are kept, so the
    // correction arithmetic is done at WIDTH bits.
    assign w_plus_q  = i_raw[WIDTH-1:0] + i_q;
    assign w_minus_q = i_raw[WIDTH-1:0] - i_q;
    assign w_ge_q    = (i_raw >= {1'b0, i_q});

    // Sub: add q back on borrow. Add: subtract q once when the sum reaches q.
    always_comb begin
        if (i_cor_op == OP_ADD) o_z = w_ge_q    ? w_minus_q : i_raw[WIDTH-1:0];
        else                    o_z = i_raw[WIDTH] ? w_plus_q : i_raw[WIDTH-1:0];
    end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Pipelined multi-lane modular add/subtract with valid/ready backpressure.
// LATENCY=2 registers the raw result between the two lane halves;
// LATENCY=1 runs both halves combinationally into the output register.
module mod_addsub_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH   = COEF_W,
    parameter int LANES   = 1,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [WIDTH-1:0]       in_q,
    input  logic [LANES*WIDTH-1:0] in_x,
    input  logic [LANES*WIDTH-1:0] in_y,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_z,
    output logic [TAG_W-1:0]       out_tag
);

    logic                          w_adv;
    logic [LANES-1:0][WIDTH:0]     w_raw;
    logic [LANES-1:0][WIDTH:0]     w_cor_raw;
    logic                          w_cor_op;
    logic [WIDTH-1:0]              w_cor_q;
    logic [TAG_W-1:0]              w_cor_tag;
    logic                          w_cor_vld;
    logic [LANES-1:0][WIDTH-1:0]   w_z;

    logic                          r_out_vld;
    logic [LANES-1:0][WIDTH-1:0]   r_z;
    logic [TAG_W-1:0]              r_tag;

    // Whole pipe moves together; only a full, unaccepted output stalls it.
    assign w_adv     = ~r_out_vld | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_vld;
    assign out_z     = r_z;
    assign out_tag   = r_tag;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        mod_addsub_lane #(.WIDTH(WIDTH)) u_lane (
            .i_x      (in_x[gi*WIDTH +: WIDTH]),
            .i_y      (in_y[gi*WIDTH +: WIDTH]),
            .i_op     (in_op),
            .o_raw    (w_raw[gi]),
            .i_raw    (w_cor_raw[gi]),
            .i_cor_op (w_cor_op),
            .i_q      (w_cor_q),
            .o_z      (w_z[gi])
        );
    end

    if (LATENCY == 2) begin : g_lat2
        logic                      r_s1_vld;
        logic [LANES-1:0][WIDTH:0] r_s1_raw;
        logic                      r_s1_op;
        logic [WIDTH-1:0]          r_s1_q;
        logic [TAG_W-1:0]          r_s1_tag;

        // Stage 1: capture raw sum/difference with the beat's own op, q and tag.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_vld <= 1'b0;
                r_s1_raw <= '0;
                r_s1_op  <= 1'b0;
                r_s1_q   <= '0;
                r_s1_tag <= '0;
            end else if (w_adv) begin
                r_s1_vld <= in_valid;
                r_s1_raw <= w_raw;
                r_s1_op  <= in_op;
                r_s1_q   <= in_q;
                r_s1_tag <= in_tag;
            end
        end

        assign w_cor_vld = r_s1_vld;
        assign w_cor_raw = r_s1_raw;
        assign w_cor_op  = r_s1_op;
        assign w_cor_q   = r_s1_q;
        assign w_cor_tag = r_s1_tag;
    end else begin : g_lat1
        assign w_cor_vld = in_valid;
        assign w_cor_raw = w_raw;
        assign w_cor_op  = in_op;
        assign w_cor_q   = in_q;
        assign w_cor_tag = in_tag;
    end

    // Output stage: register corrected result; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_z       <= '0;
            r_tag     <= '0;
        end else if (w_adv) begin
            r_out_vld <= w_cor_vld;
            r_z       <= w_z;
            r_tag     <= w_cor_tag;
        end
    end

endmodule
